// File: rtl/sb_rd_tracker_if.sv
// Issue / writeback / commit bus of the read-destination scoreboard, plus the
// per-entry producer state exported to RAW checkers.
interface sb_rd_tracker_if #(
  parameter int NR_ENTRIES    = 8,
  parameter int NUM_THREADS   = 2,
  parameter int REG_ADDR_SIZE = 6
);
  localparam int IDX_W = $clog2(NR_ENTRIES);
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                                     flush_i;
  logic                                     issue_valid_i;
  logic                                     issue_ready_o;
  logic [REG_ADDR_SIZE-1:0]                 issue_rd_i;
  logic                                     issue_rd_fpr_i;
  logic [TID_W-1:0]                         issue_tid_i;
  logic [IDX_W-1:0]                         issue_trans_id_o;
  logic                                     wb_valid_i;
  logic [IDX_W-1:0]                         wb_trans_id_i;
  logic                                     commit_valid_o;
  logic [IDX_W-1:0]                         commit_trans_id_o;
  logic                                     commit_ack_i;
  logic [NR_ENTRIES-1:0][REG_ADDR_SIZE-1:0] rd_o;
  logic [NR_ENTRIES-1:0]                    rd_fpr_o;
  logic [NR_ENTRIES-1:0][TID_W-1:0]         thread_ids_o;
  logic [NR_ENTRIES-1:0]                    still_issued_o;
  logic [IDX_W-1:0]                         issue_pointer_o;
  logic                                     empty_o;
  logic                                     full_o;

  modport master (
    output flush_i, issue_valid_i, issue_rd_i, issue_rd_fpr_i, issue_tid_i,
           wb_valid_i, wb_trans_id_i, commit_ack_i,
    input  issue_ready_o, issue_trans_id_o, commit_valid_o, commit_trans_id_o,
           rd_o, rd_fpr_o, thread_ids_o, still_issued_o, issue_pointer_o,
           empty_o, full_o
  );

  modport slave (
    input  flush_i, issue_valid_i, issue_rd_i, issue_rd_fpr_i, issue_tid_i,
           wb_valid_i, wb_trans_id_i, commit_ack_i,
    output issue_ready_o, issue_trans_id_o, commit_valid_o, commit_trans_id_o,
           rd_o, rd_fpr_o, thread_ids_o, still_issued_o, issue_pointer_o,
           empty_o, full_o
  );
endinterface

// File: rtl/sb_rd_tracker.sv
// In-order scoreboard tracking destination registers of issued instructions.
// Optional macro SB_WB_COMMIT_BYPASS_EN lets an entry commit in its writeback cycle.
module sb_rd_entry #(
  parameter int REG_ADDR_SIZE = 6,
  parameter int TID_W         = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     i_flush,
  input  logic                     i_issue,
  input  logic                     i_commit,
  input  logic                     i_wb,
  input  logic [REG_ADDR_SIZE-1:0] i_rd,
  input  logic                     i_fpr,
  input  logic [TID_W-1:0]         i_tid,
  output logic                     o_valid,
  output logic                     o_still,
  output logic [REG_ADDR_SIZE-1:0] o_rd,
  output logic                     o_fpr,
  output logic [TID_W-1:0]         o_tid
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      o_valid <= 1'b0;
      o_still <= 1'b0;
      o_rd    <= '0;
      o_fpr   <= 1'b0;
      o_tid   <= '0;
    end else if (i_flush || i_commit) begin
      o_valid <= 1'b0;
      o_still <= 1'b0;
    end else if (i_issue) begin
      o_valid <= 1'b1;
      // x0 is hardwired, so it never has an outstanding producer
      o_still <= (i_rd != '0) || i_fpr;
      o_rd    <= i_rd;
      o_fpr   <= i_fpr;
      o_tid   <= i_tid;
    end else if (i_wb && o_valid) begin
      o_still <= 1'b0;
    end
  end
endmodule

module sb_rd_tracker #(
  parameter int NR_ENTRIES    = 8,
  parameter int NUM_THREADS   = 2,
  parameter int REG_ADDR_SIZE = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  sb_rd_tracker_if.slave bus
);
  localparam int IDX_W = $clog2(NR_ENTRIES);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam logic [IDX_W:0] FULL_CNT = NR_ENTRIES[IDX_W:0];

  logic [IDX_W-1:0]                         r_iptr, r_cptr;
  logic [IDX_W:0]                           r_cnt;
  logic [NR_ENTRIES-1:0]                    w_valid, w_still, w_fpr;
  logic [NR_ENTRIES-1:0][REG_ADDR_SIZE-1:0] w_rd;
  logic [NR_ENTRIES-1:0][TID_W-1:0]         w_tid;
  logic w_full, w_empty, w_ready, w_issue, w_cvalid, w_commit;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  assign w_ready = !w_full && !bus.flush_i;
  assign w_issue = bus.issue_valid_i && w_ready;
`ifdef SB_WB_COMMIT_BYPASS_EN
  assign w_cvalid = w_valid[r_cptr] &&
                    (!w_still[r_cptr] || (bus.wb_valid_i && bus.wb_trans_id_i == r_cptr));
`else
  assign w_cvalid = w_valid[r_cptr] && !w_still[r_cptr];
`endif
  assign w_commit = w_cvalid && bus.commit_ack_i;

  for (genvar i = 0; i < NR_ENTRIES; i++) begin : g_ent
    sb_rd_entry #(.REG_ADDR_SIZE(REG_ADDR_SIZE), .TID_W(TID_W)) u_ent (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_flush  (bus.flush_i),
      .i_issue  (w_issue && (r_iptr == IDX_W'(i))),
      .i_commit (w_commit && (r_cptr == IDX_W'(i))),
      .i_wb     (bus.wb_valid_i && (bus.wb_trans_id_i == IDX_W'(i))),
      .i_rd     (bus.issue_rd_i),
      .i_fpr    (bus.issue_rd_fpr_i),
      .i_tid    (bus.issue_tid_i),
      .o_valid  (w_valid[i]),
      .o_still  (w_still[i]),
      .o_rd     (w_rd[i]),
      .o_fpr    (w_fpr[i]),
      .o_tid    (w_tid[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_iptr <= '0;
      r_cptr <= '0;
      r_cnt  <= '0;
    end else if (bus.flush_i) begin
      r_iptr <= '0;
      r_cptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_issue)  r_iptr <= r_iptr + 1'b1;
      if (w_commit) r_cptr <= r_cptr + 1'b1;
      if (w_issue && !w_commit)      r_cnt <= r_cnt + 1'b1;
      else if (!w_issue && w_commit) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.issue_ready_o     = w_ready;
  assign bus.issue_trans_id_o  = r_iptr;
  assign bus.issue_pointer_o   = r_iptr;
  assign bus.commit_valid_o    = w_cvalid;
  assign bus.commit_trans_id_o = r_cptr;
  assign bus.rd_o              = w_rd;
  assign bus.rd_fpr_o          = w_fpr;
  assign bus.thread_ids_o      = w_tid;
  assign bus.still_issued_o    = w_still;
  assign bus.empty_o           = w_empty;
  assign bus.full_o            = w_full;
endmodule

// File: tb/tb_sb_rd_tracker.sv
// Directed test of sb_rd_tracker: issue, x0 handling, wrap, writeback/commit, flush, reset.
module tb_sb_rd_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sb_rd_tracker_if #(.NR_ENTRIES(8), .NUM_THREADS(2), .REG_ADDR_SIZE(6)) bus ();

  sb_rd_tracker #(.NR_ENTRIES(8), .NUM_THREADS(2), .REG_ADDR_SIZE(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i        = 1'b0;
    bus.issue_valid_i  = 1'b0;
    bus.issue_rd_i     = '0;
    bus.issue_rd_fpr_i = 1'b0;
    bus.issue_tid_i    = '0;
    bus.wb_valid_i     = 1'b0;
    bus.wb_trans_id_i  = '0;
    bus.commit_ack_i   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic issue_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.issue_valid_i = 1'b1;
      bus.issue_rd_i    = 6'(k + 1);
      step();
    end
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %0b exp 1", bus.empty_o); end
    n_cmp++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL rst_full: got %0b exp 0", bus.full_o); end
    n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_cvalid: got %0b exp 0", bus.commit_valid_o); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd0) begin n_err++; $display("FAIL rst_iptr: got %0d exp 0", bus.issue_pointer_o); end
    n_cmp++; if (bus.still_issued_o !== 8'h00) begin n_err++; $display("FAIL rst_still: got %0h exp 0", bus.still_issued_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0b exp 1", bus.issue_ready_o); end
  endtask

  task automatic test_issue();
    do_reset();
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 6'd5; bus.issue_tid_i = 1'b1;
    #1;
    n_cmp++; if (bus.issue_trans_id_o !== 3'd0) begin n_err++; $display("FAIL iss_tid: got %0d exp 0", bus.issue_trans_id_o); end
    step();
    idle_inputs();
    n_cmp++; if (bus.still_issued_o !== 8'h01) begin n_err++; $display("FAIL iss_still: got %0h exp 01", bus.still_issued_o); end
    n_cmp++; if (bus.rd_o[0] !== 6'd5) begin n_err++; $display("FAIL iss_rd: got %0d exp 5", bus.rd_o[0]); end
    n_cmp++; if (bus.thread_ids_o[0] !== 1'b1) begin n_err++; $display("FAIL iss_thr: got %0d exp 1", bus.thread_ids_o[0]); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd1) begin n_err++; $display("FAIL iss_iptr: got %0d exp 1", bus.issue_pointer_o); end
    n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL iss_cv_pend: got %0b exp 0", bus.commit_valid_o); end
    bus.wb_valid_i = 1'b1; bus.wb_trans_id_i = 3'd0;
    step();
    idle_inputs();
    n_cmp++; if (bus.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL iss_cv_wb: got %0b exp 1", bus.commit_valid_o); end
    bus.commit_ack_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL iss_empty: got %0b exp 1", bus.empty_o); end
    n_cmp++; if (bus.commit_trans_id_o !== 3'd1) begin n_err++; $display("FAIL iss_cptr: got %0d exp 1", bus.commit_trans_id_o); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    issue_n(8);
    n_cmp++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %0b exp 1", bus.full_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b exp 0", bus.issue_ready_o); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd0) begin n_err++; $display("FAIL full_iptr: got %0d exp 0", bus.issue_pointer_o); end
    bus.wb_valid_i = 1'b1; bus.wb_trans_id_i = 3'd0;
    step();
    idle_inputs();
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 6'd20; bus.commit_ack_i = 1'b1;
    #1;
    n_cmp++; if (bus.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL full_cv: got %0b exp 1", bus.commit_valid_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL full_nobyp: got %0b exp 0", bus.issue_ready_o); end
    step();
    bus.commit_ack_i = 1'b0;
    bus.issue_valid_i = 1'b0;
    n_cmp++; if (bus.full_o !== 1'b0) begin n_err++; $display("FAIL full_cnt7: got %0b exp 0", bus.full_o); end
    n_cmp++; if (bus.rd_o[0] !== 6'd1) begin n_err++; $display("FAIL full_noiss: got %0d exp 1", bus.rd_o[0]); end
    n_cmp++; if (bus.commit_trans_id_o !== 3'd1) begin n_err++; $display("FAIL full_cptr: got %0d exp 1", bus.commit_trans_id_o); end
    bus.issue_valid_i = 1'b1;
    step();
    idle_inputs();
    n_cmp++; if (bus.rd_o[0] !== 6'd20) begin n_err++; $display("FAIL wrap_rd: got %0d exp 20", bus.rd_o[0]); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd1) begin n_err++; $display("FAIL wrap_iptr: got %0d exp 1", bus.issue_pointer_o); end
    n_cmp++; if (bus.still_issued_o !== 8'hFF) begin n_err++; $display("FAIL wrap_still: got %0h exp ff", bus.still_issued_o); end
    n_cmp++; if (bus.full_o !== 1'b1) begin n_err++; $display("FAIL wrap_full: got %0b exp 1", bus.full_o); end
  endtask

  task automatic test_x0();
    do_reset();
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 6'd0; bus.issue_rd_fpr_i = 1'b0;
    step();
    bus.issue_rd_fpr_i = 1'b1;
    n_cmp++; if (bus.still_issued_o[0] !== 1'b0) begin n_err++; $display("FAIL x0_still: got %0b exp 0", bus.still_issued_o[0]); end
    n_cmp++; if (bus.commit_valid_o !== 1'b1) begin n_err++; $display("FAIL x0_cv: got %0b exp 1", bus.commit_valid_o); end
    step();
    idle_inputs();
    n_cmp++; if (bus.still_issued_o[1] !== 1'b1) begin n_err++; $display("FAIL f0_still: got %0b exp 1", bus.still_issued_o[1]); end
    n_cmp++; if (bus.rd_fpr_o[1] !== 1'b1) begin n_err++; $display("FAIL f0_fpr: got %0b exp 1", bus.rd_fpr_o[1]); end
  endtask

  task automatic test_wb_commit();
    logic exp_cv;
`ifdef SB_WB_COMMIT_BYPASS_EN
    exp_cv = 1'b1;
`else
    exp_cv = 1'b0;
`endif
    do_reset();
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 6'd3;
    step();
    idle_inputs();
    bus.wb_valid_i = 1'b1; bus.wb_trans_id_i = 3'd0; bus.commit_ack_i = 1'b1;
    #1;
    n_cmp++; if (bus.commit_valid_o !== exp_cv) begin n_err++; $display("FAIL wbc_cv: got %0b exp %0b", bus.commit_valid_o, exp_cv); end
    step();
    bus.wb_valid_i = 1'b0;
    n_cmp++; if (bus.empty_o !== exp_cv) begin n_err++; $display("FAIL wbc_empty1: got %0b exp %0b", bus.empty_o, exp_cv); end
    step();
    idle_inputs();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL wbc_empty2: got %0b exp 1", bus.empty_o); end
    n_cmp++; if (bus.commit_trans_id_o !== 3'd1) begin n_err++; $display("FAIL wbc_cptr: got %0d exp 1", bus.commit_trans_id_o); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_n(4);
    n_cmp++; if (bus.still_issued_o !== 8'h0F) begin n_err++; $display("FAIL fl_pre: got %0h exp 0f", bus.still_issued_o); end
    bus.flush_i = 1'b1; bus.issue_valid_i = 1'b1; bus.issue_rd_i = 6'd9;
    bus.wb_valid_i = 1'b1; bus.wb_trans_id_i = 3'd2;
    #1;
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_err++; $display("FAIL fl_ready: got %0b exp 0", bus.issue_ready_o); end
    step();
    idle_inputs();
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL fl_empty: got %0b exp 1", bus.empty_o); end
    n_cmp++; if (bus.still_issued_o !== 8'h00) begin n_err++; $display("FAIL fl_still: got %0h exp 0", bus.still_issued_o); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd0) begin n_err++; $display("FAIL fl_iptr: got %0d exp 0", bus.issue_pointer_o); end
    n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL fl_cv: got %0b exp 0", bus.commit_valid_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_n(3);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL ar_empty: got %0b exp 1", bus.empty_o); end
    n_cmp++; if (bus.still_issued_o !== 8'h00) begin n_err++; $display("FAIL ar_still: got %0h exp 0", bus.still_issued_o); end
    n_cmp++; if (bus.issue_pointer_o !== 3'd0) begin n_err++; $display("FAIL ar_iptr: got %0d exp 0", bus.issue_pointer_o); end
    n_cmp++; if (bus.rd_o[1] !== 6'd0) begin n_err++; $display("FAIL ar_rd: got %0d exp 0", bus.rd_o[1]); end
    step();
    rst = 1'b0;
    bus.wb_valid_i = 1'b1; bus.wb_trans_id_i = 3'd1;
    step();
    idle_inputs();
    n_cmp++; if (bus.commit_valid_o !== 1'b0) begin n_err++; $display("FAIL ar_wb_cv: got %0b exp 0", bus.commit_valid_o); end
    n_cmp++; if (bus.empty_o !== 1'b1) begin n_err++; $display("FAIL ar_wb_empty: got %0b exp 1", bus.empty_o); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_full_wrap();
    test_x0();
    test_wb_commit();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
